// File: rtl/real_ramp_pkg.sv
// Shared types and elaboration-time helpers for the real-valued ramp generator.
package real_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Real to signed Q(frac) with round-to-nearest, ties away from zero, clamped to width bits.
  function automatic int to_q(real r, int frac, int width);
    real scaled;
    int  q_max;
    int  q_min;
    int  q;
    scaled = r * (2.0 ** frac);
    q_max  = (1 << (width - 1)) - 1;
    q_min  = -(1 << (width - 1));
    if (scaled >= real'(q_max)) return q_max;
    if (scaled <= real'(q_min)) return q_min;
    if (scaled >= 0.0) q = $rtoi(scaled + 0.5);
    else               q = -$rtoi(-scaled + 0.5);
    return q;
  endfunction

endpackage

// File: rtl/real_ramp_step.sv
// Combinational signed step add; saturates by default, wraps when REAL_RAMP_WRAP_EN is defined.
module real_ramp_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] step,
  output logic signed [WIDTH-1:0] sum_c,
  output logic                    ovf_c
);

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] ext;

  always_comb begin
    ext = {a[WIDTH-1], a} + {step[WIDTH-1], step};
`ifdef REAL_RAMP_WRAP_EN
    sum_c = ext[WIDTH-1:0];
    ovf_c = 1'b0;
`else
    // Sign bits of the WIDTH+1 result disagree only on overflow.
    ovf_c = ext[WIDTH] ^ ext[WIDTH-1];
    if (ovf_c) sum_c = ext[WIDTH] ? S_MIN : S_MAX;
    else       sum_c = ext[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/real_ramp_gen.sv
// Fixed-point ramp source with valid/ready output; start/step given as real parameters.
// Optional build macro REAL_RAMP_WRAP_EN: step add wraps and sat_o stays 0.
module real_ramp_gen
  import real_ramp_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned FRAC    = 4,
  parameter real         START_R = 0.5,
  parameter real         STEP_R  = 0.25,
  parameter int unsigned COUNT   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sat_o
);

  localparam int START_QI = to_q(START_R, int'(FRAC), int'(WIDTH));
  localparam int STEP_QI  = to_q(STEP_R, int'(FRAC), int'(WIDTH));
  localparam logic signed [WIDTH-1:0] START_Q = WIDTH'(START_QI);
  localparam logic signed [WIDTH-1:0] STEP_Q  = WIDTH'(STEP_QI);

  localparam int unsigned IDX_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  state_e                  state_q, state_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic signed [WIDTH-1:0] data_q, data_n;
  logic                    valid_q, valid_n;
  logic                    last_q, last_n;
  logic                    busy_q, busy_n;
  logic                    done_q, done_n;
  logic                    sat_q, sat_n;
  logic                    abort_q, abort_n;

  logic signed [WIDTH-1:0] sum_c;
  logic                    ovf_c;
  logic                    xfer_c;

  real_ramp_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a     (data_q),
    .step  (STEP_Q),
    .sum_c (sum_c),
    .ovf_c (ovf_c)
  );

  assign xfer_c = valid_q & ready_i;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    sat_n   = sat_q;
    abort_n = abort_q;

    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (start_i) begin
          state_n = RUN;
          idx_n   = '0;
          data_n  = START_Q;
          valid_n = 1'b1;
          last_n  = (COUNT == 1);
          busy_n  = 1'b1;
          sat_n   = 1'b0;
          abort_n = 1'b0;
        end
      end
      RUN: begin
        if (xfer_c) begin
          // An abort seen before or with this beat makes it the final one.
          if (last_q || abort_q || stop_i) begin
            state_n = DONE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
            abort_n = 1'b0;
          end else begin
            idx_n  = IDX_W'(idx_q + 1'b1);
            data_n = sum_c;
            last_n = (IDX_W'(idx_q + 1'b1) == LAST_IDX);
            sat_n  = sat_q | ovf_c;
          end
        end else if (stop_i) begin
          abort_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      sat_q   <= sat_n;
      abort_q <= abort_n;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_real_ramp_gen.sv
// Scoreboard bench for real_ramp_gen: four parameterisations, beats checked by a separate monitor.
module tb_real_ramp_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] start, stop, ready;
  logic [3:0] valid, last, busy, done, sat;
  logic signed [7:0] data [4];

  typedef struct {
    int data;
    bit last;
  } beat_t;

  beat_t exp_q [4][$];
  int errors = 0;
  int checks = 0;

`ifdef REAL_RAMP_WRAP_EN
  localparam int SAT_EXP = 0;
`else
  localparam int SAT_EXP = 1;
`endif

  always #5 clk = ~clk;

  real_ramp_gen #(.COUNT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .stop_i(stop[0]), .ready_i(ready[0]),
    .valid_o(valid[0]), .data_o(data[0]), .last_o(last[0]), .busy_o(busy[0]),
    .done_o(done[0]), .sat_o(sat[0]));

  real_ramp_gen #(.START_R(7.5), .STEP_R(1.0), .COUNT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .stop_i(stop[1]), .ready_i(ready[1]),
    .valid_o(valid[1]), .data_o(data[1]), .last_o(last[1]), .busy_o(busy[1]),
    .done_o(done[1]), .sat_o(sat[1]));

  real_ramp_gen #(.START_R(0.03125), .STEP_R(-0.5), .COUNT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .stop_i(stop[2]), .ready_i(ready[2]),
    .valid_o(valid[2]), .data_o(data[2]), .last_o(last[2]), .busy_o(busy[2]),
    .done_o(done[2]), .sat_o(sat[2]));

  real_ramp_gen #(.COUNT(1)) u_d (
    .clk(clk), .rst_n(rst_n), .start_i(start[3]), .stop_i(stop[3]), .ready_i(ready[3]),
    .valid_o(valid[3]), .data_o(data[3]), .last_o(last[3]), .busy_o(busy[3]),
    .done_o(done[3]), .sat_o(sat[3]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int d, input bit l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q[k].push_back(b);
  endtask

  // Pops one expected beat per observed transfer.
  task automatic monitor();
    beat_t b;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (valid[k] && ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("dut%0d_unexpected_beat", k), int'(data[k]), -999);
          end else begin
            b = exp_q[k].pop_front();
            chk($sformatf("dut%0d_data", k), int'(data[k]), b.data);
            chk($sformatf("dut%0d_last", k), int'(last[k]), int'(b.last));
          end
        end
      end
    end
  endtask

  task automatic start_burst(input int k);
    ready[k] = 1'b1;
    start[k] = 1'b1;
    tick(1);
    start[k] = 1'b0;
    chk($sformatf("dut%0d_valid_latency", k), int'(valid[k]), 1);
  endtask

  task automatic wait_done(input int k);
    int cyc;
    cyc = 0;
    while (!done[k] && cyc < 50) begin
      tick(1);
      cyc++;
    end
    chk($sformatf("dut%0d_done_pulse", k), int'(done[k]), 1);
    chk($sformatf("dut%0d_busy_in_done", k), int'(busy[k]), 1);
    chk($sformatf("dut%0d_valid_in_done", k), int'(valid[k]), 0);
    tick(1);
    chk($sformatf("dut%0d_done_cleared", k), int'(done[k]), 0);
    chk($sformatf("dut%0d_busy_cleared", k), int'(busy[k]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    stop  = '0;
    ready = '0;
    fork
      monitor();
    join_none

    tick(2);
    chk("reset_valid", int'(valid[0]), 0);
    chk("reset_data", int'(data[0]), 0);
    chk("reset_last", int'(last[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_sat", int'(sat[0]), 0);
    rst_n = 1'b1;
    tick(1);

    // Plain burst of four beats with ready held high.
    push(0, 8, 0); push(0, 12, 0); push(0, 16, 0); push(0, 20, 1);
    start_burst(0);
    tick(3);
    chk("a_last_beat_data", int'(data[0]), 20);
    chk("a_done_not_early", int'(done[0]), 0);
    tick(1);
    chk("a_done_after_last", int'(done[0]), 1);
    chk("a_valid_dropped", int'(valid[0]), 0);
    tick(1);
    chk("a_busy_idle", int'(busy[0]), 0);
    tick(1);

    // Stall three cycles after the first beat.
    push(0, 8, 0); push(0, 12, 0); push(0, 16, 0); push(0, 20, 1);
    start_burst(0);
    tick(1);
    ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("a_stall_data", int'(data[0]), 12);
      chk("a_stall_valid", int'(valid[0]), 1);
    end
    ready[0] = 1'b1;
    wait_done(0);

    // Saturating (or wrapping) step.
    push(1, 120, 0);
`ifdef REAL_RAMP_WRAP_EN
    push(1, -120, 0); push(1, -104, 1);
`else
    push(1, 127, 0); push(1, 127, 1);
`endif
    start_burst(1);
    chk("b_sat_clear_at_start", int'(sat[1]), 0);
    wait_done(1);
    chk("b_sat_sticky", int'(sat[1]), SAT_EXP);
    push(1, 120, 0);
`ifdef REAL_RAMP_WRAP_EN
    push(1, -120, 0); push(1, -104, 1);
`else
    push(1, 127, 0); push(1, 127, 1);
`endif
    start_burst(1);
    chk("b_sat_cleared_on_restart", int'(sat[1]), 0);
    wait_done(1);

    // Tie rounding away from zero and negative step.
    push(2, 1, 0); push(2, -7, 0); push(2, -15, 1);
    start_burst(2);
    chk("c_start_q", int'(data[2]), 1);
    wait_done(2);

    // Abort while beat 2 is stalled.
    push(0, 8, 0); push(0, 12, 0); push(0, 16, 0);
    start_burst(0);
    tick(2);
    ready[0] = 1'b0;
    tick(1);
    stop[0] = 1'b1;
    tick(1);
    stop[0] = 1'b0;
    tick(1);
    chk("abort_hold_data", int'(data[0]), 16);
    chk("abort_hold_valid", int'(valid[0]), 1);
    chk("abort_hold_last", int'(last[0]), 0);
    ready[0] = 1'b1;
    tick(1);
    chk("abort_done", int'(done[0]), 1);
    chk("abort_valid_low", int'(valid[0]), 0);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    chk("done_start_ignored_busy", int'(busy[0]), 0);
    chk("done_start_ignored_done", int'(done[0]), 0);
    tick(1);
    chk("done_start_not_queued", int'(valid[0]), 0);

    // Single-beat burst.
    push(3, 8, 1);
    start_burst(3);
    chk("d_single_last", int'(last[3]), 1);
    wait_done(3);

    // Asynchronous reset in the middle of a stalled burst.
    start_burst(0);
    ready[0] = 1'b0;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(valid[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rst_no_done", int'(done[0]), 0);
    push(0, 8, 0); push(0, 12, 0); push(0, 16, 0); push(0, 20, 1);
    start_burst(0);
    chk("rst_restart_data", int'(data[0]), 8);
    wait_done(0);

    tick(2);
    for (int k = 0; k < 4; k++) chk($sformatf("dut%0d_beats_drained", k), exp_q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
